alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares the single combinational 32-bit ALU between NREQ requesters, e.g. the branch-target unit and the execute stage.
//  Round-robin arbitration; one transaction in flight at a time.
//  Operands and result are registered, so the ALU path is isolated from the requester logic.
//  Sits between the requesters and the ALU instance; drives the ALU's operands and control, and samples its result and flags.
// PARAMETERS
//  NREQ  2   number of requesters (2..8)
//  DW    32  operand/result width; must match the ALU
//  OPW   3   ALU control width
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         asynchronous reset, active low
//  req_valid   in   NREQ      requester i has an operation pending
//  req_ready   out  NREQ      one-hot; request i accepted this cycle
//  req_a       in   NREQ*DW   operand A, requester i at [i*DW +: DW]
//  req_b       in   NREQ*DW   operand B, same packing as req_a
//  req_op      in   NREQ*OPW  ALU control, same packing
//  rsp_valid   out  NREQ      one-hot; result for requester i is valid
//  rsp_ready   in   NREQ      requester i takes its result
//  rsp_result  out  DW        registered ALU result
//  rsp_zero    out  1         registered Zero flag
//  rsp_sign    out  1         registered sign flag (result[DW-1])
//  alu_a       out  DW        drives ALU operand A
//  alu_b       out  DW        drives ALU operand B
//  alu_ctrl    out  OPW       drives ALU control
//  alu_result  in   DW        ALU result
//  alu_zero    in   1         ALU Zero flag
//  alu_sign    in   1         ALU sign flag
// BEHAVIOUR
//  Reset values
//   - All outputs 0; FSM in IDLE; rr_ptr = 0; operand, result and owner registers 0.
//   - Reset mid-transaction silently drops the transaction; no rsp_valid is issued for it.
//  IDLE state
//   - If any req_valid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... (mod NREQ).
//   - In that same cycle: pulse req_ready[win]; latch a, b, op and owner = win; go to EXEC.
//  EXEC state
//   - alu_a / alu_b / alu_ctrl come from the latched registers.
//   - Capture alu_result, alu_zero and alu_sign at the clock edge; go to RESP.
//  RESP state
//   - Hold rsp_valid[owner] = 1 with the result stable until rsp_ready[owner] = 1.
//   - On that cycle: rr_ptr <= (owner+1) mod NREQ; go to IDLE.
//   - rsp_ready on any non-owner bit is ignored.
//  ALU drive outside EXEC
//   - alu_a / alu_b / alu_ctrl keep their latched values; they never glitch to requester inputs.
//  Latency and throughput
//   - Accept in cycle N; rsp_valid rises in cycle N+2.
//   - Best-case throughput is 1 op per 3 cycles (rsp_ready asserted in the first RESP cycle).
//   - No new accept is possible while in EXEC or RESP; req_ready stays 0 there.
//  Operations
//   - op is passed through unchecked.
//   - Encoding 3'b011 is unused by the ALU; it yields result 0 and zero = 1, and is still returned normally.
//  Fairness
//   - With all requesters valid continuously, grants rotate 0, 1, ..., NREQ-1, 0.
//  Boundary cases
//   - A single active requester is granted back-to-back.
//   - A requester may drop req_valid before it is granted; no grant is made for it.
//   - req_valid and rsp_ready from the same requester in the same RESP cycle: the response completes and the FSM returns to IDLE; the new request is arbitrated in the next cycle.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined
//   - Adds output grant_cnt (NREQ*16): per-requester saturating grant counters, incremented on each req_ready pulse, reset to 0.
//   - Adds input stats_clr (1): synchronous clear of all counters; it takes precedence over an increment in the same cycle.
//  ALU_ARB_STATS_EN undefined
//   - Ports grant_cnt and stats_clr do not exist; there is no counter logic.
// STRUCTURE
//  alu_pkg
//   - ALU op localparams (ALU_ADD = 3'b000, ALU_SLL = 3'b001, ALU_SUB = 3'b010, ALU_XOR = 3'b100, ALU_SRL = 3'b101, ALU_OR = 3'b110, ALU_AND = 3'b111).
//   - FSM state encoding IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
//  rr_pick
//   - One sub-module: combinational round-robin picker.
//   - Inputs: req vector and rr_ptr. Outputs: one-hot grant and binary index.
//  Top level
//   - FSM, operand/result registers and optional counters.
// TESTING
//  1. Single op: rst_n low then high; req0 a = 5, b = 3, op = 000 -> req_ready[0] in accept cycle, rsp_valid[0] 2 cycles later, result = 8, zero = 0.
//  2. Sign and zero: req1 a = 3, b = 5, op = 010 -> result 32'hFFFFFFFE, sign = 1; then a = 7, b = 7, op = 010 -> zero = 1.
//  3. Fairness: both valid for 6 grants -> grant order 0, 1, 0, 1, 0, 1; no starvation.
//  4. Backpressure: hold rsp_ready[0] = 0 for 4 cycles -> rsp_valid[0] and result stable, req_ready[1] stays 0; release -> req1 granted next cycle.
//  5. Reset in EXEC: assert rst_n = 0 mid-op -> all outputs 0 immediately, no rsp_valid afterwards, next grant goes to req0.
//  6. ALU_ARB_STATS_EN: 3 grants to req0, 2 to req1 -> grant_cnt = {16'd2, 16'd3}; pulse stats_clr -> all counters 0.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU request arbiter:
//   - ALU control encodings (3'b011 is unused by the ALU and yields 0)
//   - arbiter FSM state encoding
//   - grant counter width and a pointer-width helper
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Width of each per-requester saturating grant counter.
  localparam int CNT_W = 16;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans req starting at rr_ptr and wrapping
// modulo NREQ; the first set bit wins.
// Ports:
//   req        in   NREQ  request vector
//   rr_ptr     in   PW    index with highest priority this cycle
//   grant      out  NREQ  one-hot winner (0 when no request)
//   grant_idx  out  PW    binary index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_pick
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    grant     = '0;
    grant_idx = '0;
    // Walk offsets from farthest to nearest; later hits overwrite earlier
    // ones, so the set bit closest to rr_ptr ends up as the winner.
    for (int off = NREQ - 1; off >= 0; off--) begin
      for (int j = 0; j < NREQ; j++) begin
        if ((j == (int'(rr_ptr) + off) % NREQ) && req[j]) begin
          grant     = '0;
          grant[j]  = 1'b1;
          grant_idx = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
// Shares one combinational ALU between NREQ requesters. Round-robin grant,
// one transaction in flight: IDLE (accept) -> EXEC (ALU evaluates latched
// operands) -> RESP (hold result until the owner takes it).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot)
//   req_a/req_b/req_op         packed per-requester operands and ALU control
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_result/zero/sign       registered ALU result and flags
//   alu_a/alu_b/alu_ctrl       registered ALU drive
//   alu_result/zero/sign       ALU outputs
// Optional (macro ALU_ARB_STATS_EN):
//   stats_clr                  synchronous clear of the grant counters
//   grant_cnt                  NREQ x 16-bit saturating grant counters
// ---------------------------------------------------------------------------
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int OPW  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [DW-1:0]       rsp_result,
  output logic                rsp_zero,
  output logic                rsp_sign,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [OPW-1:0]      alu_ctrl,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_zero,
  input  logic                alu_sign
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int PW = ptr_w(NREQ);

  arb_state_e     state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [DW-1:0]  a_q, a_d, b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  result_q, result_d;
  logic           zero_q, zero_d, sign_q, sign_d;

  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic [DW-1:0]   sel_a, sel_b;
  logic [OPW-1:0]  sel_op;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_a  = req_a[i*DW +: DW];
        sel_b  = req_b[i*DW +: DW];
        sel_op = req_op[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    sign_d    = sign_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        // The grant is qualified with rst_n so req_ready stays 0 while reset
        // is held, even though the picker is purely combinational.
        if (rst_n && (|req_valid)) begin
          req_ready = pick_grant;
          owner_d   = pick_idx;
          a_d       = sel_a;
          b_d       = sel_b;
          op_d      = sel_op;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        sign_d   = alu_sign;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        // Only the owner's rsp_ready can complete the response.
        if (rsp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the operand and result registers are reset along with the
    // control state, because the ALU drive and response outputs must read 0
    // out of reset.
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only, so every flop
      // samples the pre-edge value of its _d regardless of statement order.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  // ALU drive comes only from the latched registers, so it never follows the
  // requester inputs outside EXEC.
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_sign   = sign_q;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (req_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
// Self-checking bench for alu_req_arbiter (NREQ = 2). The bench owns the ALU
// model that answers the arbiter's ALU port. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int OPW  = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_a, req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [DW-1:0]       rsp_result;
  logic                rsp_zero, rsp_sign;
  logic [DW-1:0]       alu_a, alu_b;
  logic [OPW-1:0]      alu_ctrl;
  logic [DW-1:0]       alu_result;
  logic                alu_zero, alu_sign;
`ifdef ALU_ARB_STATS_EN
  logic                stats_clr;
  logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ptr  = 0;   // reference round-robin pointer

  always #5 clk = ~clk;

  // Behavioural ALU: 3'b011 and any unknown encoding yield 0.
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, b,
                                           input logic [OPW-1:0] op);
    case (op)
      ALU_ADD: return a + b;
      ALU_SLL: return a << b[4:0];
      ALU_SUB: return a - b;
      ALU_XOR: return a ^ b;
      ALU_SRL: return a >> b[4:0];
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);
  assign alu_sign   = alu_result[DW-1];

  alu_req_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_sign   (rsp_sign),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_sign   (alu_sign)
`ifdef ALU_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int who, input logic [DW-1:0] a, b, input logic [OPW-1:0] op);
    req_a[who*DW +: DW]    = a;
    req_b[who*DW +: DW]    = b;
    req_op[who*OPW +: OPW] = op;
    req_valid[who]         = 1'b1;
  endtask

  // Entered at the falling edge of the accept cycle. Leaves req_valid = keep
  // during EXEC/RESP, holds rsp_ready off the owner for 'hold' cycles (with the
  // non-owner bits set, which must be ignored), then acknowledges.
  // Returns 1 ns after the edge that moves the FSM back to IDLE.
  task automatic complete(input int win, input logic [DW-1:0] er, input logic ez,
                          input logic es, input int hold, input logic [NREQ-1:0] keep);
    @(posedge clk); #1;
    req_valid = keep;
    @(negedge clk);
    check("exec_rsp_valid", rsp_valid, '0);
    check("exec_req_ready", req_ready, '0);
    @(negedge clk);
    check("rsp_valid", rsp_valid, oh(win));
    check("rsp_result", rsp_result, er);
    check("rsp_zero", rsp_zero, ez);
    check("rsp_sign", rsp_sign, es);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh(win);
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, oh(win));
      check("hold_rsp_result", rsp_result, er);
      check("hold_req_ready", req_ready, '0);
    end
    rsp_ready = oh(win);
    @(posedge clk); #1;
    rsp_ready = '0;
    exp_ptr = (win + 1) % NREQ;
  endtask

  task automatic transact(input int win, input logic [DW-1:0] er, input logic ez,
                          input logic es, input int hold, input logic [NREQ-1:0] keep);
    @(negedge clk);
    check("accept", req_ready, oh(win));
    complete(win, er, ez, es, hold, keep);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_result", rsp_result, '0);
    check("rst_alu_a", alu_a, '0);
    rst_n = 1'b1;
    exp_ptr = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int              who;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [OPW-1:0]  op;
    logic [DW-1:0]   res;
    logic            z;
    logic            s;
  } vec_t;

  vec_t vt[11];

  initial begin
    int grants, last_c, g;
    logic [DW-1:0] er;
    logic [NREQ-1:0] vec;
    int win, hold;

    vt[0]  = '{0, 32'd5,          32'd3,   3'b000, 32'd8,          1'b0, 1'b0};
    vt[1]  = '{1, 32'd3,          32'd5,   3'b010, 32'hFFFF_FFFE,  1'b0, 1'b1};
    vt[2]  = '{1, 32'd7,          32'd7,   3'b010, 32'd0,          1'b1, 1'b0};
    vt[3]  = '{0, 32'd1,          32'd4,   3'b001, 32'd16,         1'b0, 1'b0};
    vt[4]  = '{1, 32'h0000_00F0,  32'hFF,  3'b100, 32'h0000_000F,  1'b0, 1'b0};
    vt[5]  = '{0, 32'h8000_0000,  32'd31,  3'b101, 32'd1,          1'b0, 1'b0};
    vt[6]  = '{1, 32'h0000_00F0,  32'h0F,  3'b110, 32'h0000_00FF,  1'b0, 1'b0};
    vt[7]  = '{0, 32'h0000_00F0,  32'h0F,  3'b111, 32'd0,          1'b1, 1'b0};
    vt[8]  = '{1, 32'd123,        32'd456, 3'b011, 32'd0,          1'b1, 1'b0};
    vt[9]  = '{0, 32'hFFFF_FFFF,  32'd1,   3'b000, 32'd0,          1'b1, 1'b0};
    vt[10] = '{1, 32'h4000_0000,  32'd1,   3'b001, 32'h8000_0000,  1'b0, 1'b1};

    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    do_reset();

    // Fairness: both requesters always valid, owner always ready.
    set_req(0, 32'd10, 32'd1, ALU_ADD);
    set_req(1, 32'd20, 32'd2, ALU_SUB);
    rsp_ready = '1;
    grants = 0;
    last_c = 0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = (req_ready[1]) ? 1 : 0;
        check("fair_grant", req_ready, oh(exp_ptr));
        if (grants > 0) check("fair_spacing", c - last_c, 3);
        last_c = c;
        exp_ptr = (g + 1) % NREQ;
        grants++;
      end
    end
    check("fair_grant_count", grants, 6);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = '0;

    // Table of single-requester operations.
    for (int i = 0; i < 11; i++) begin
      set_req(vt[i].who, vt[i].a, vt[i].b, vt[i].op);
      transact(vt[i].who, vt[i].res, vt[i].z, vt[i].s, 0, '0);
    end

    // Backpressure: req0 held in RESP for 4 cycles while req1 waits.
    set_req(0, 32'd100, 32'd1, ALU_SUB);
    set_req(1, 32'd2, 32'd3, ALU_ADD);
    req_valid = 2'b01;
    transact(0, 32'd99, 1'b0, 1'b0, 4, 2'b10);
    @(negedge clk);
    check("bp_next_grant", req_ready, oh(1));
    complete(1, 32'd5, 1'b0, 1'b0, 0, '0);

    // Request dropped before it is granted.
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    transact(0, 32'd2, 1'b0, 1'b0, 0, 2'b10);
    req_valid = '0;
    @(negedge clk);
    check("drop_no_grant", req_ready, '0);
    @(negedge clk);
    check("drop_no_exec", rsp_valid, '0);
    @(posedge clk); #1;

    // Same-requester req_valid and rsp_ready in RESP, then back-to-back grant.
    set_req(0, 32'd9, 32'd4, ALU_SUB);
    transact(0, 32'd5, 1'b0, 1'b0, 0, 2'b01);
    @(negedge clk);
    check("b2b_grant", req_ready, oh(0));
    complete(0, 32'd5, 1'b0, 1'b0, 0, '0);

    // Reset while in EXEC.
    set_req(1, 32'hAA, 32'h55, ALU_OR);
    req_valid = 2'b10;
    @(negedge clk);
    check("rst_exec_accept", req_ready, oh(1));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstx_req_ready", req_ready, '0);
    check("rstx_rsp_valid", rsp_valid, '0);
    check("rstx_rsp_result", rsp_result, '0);
    check("rstx_alu_a", alu_a, '0);
    check("rstx_alu_b", alu_b, '0);
    check("rstx_alu_ctrl", alu_ctrl, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstx_no_rsp", rsp_valid, '0);
    end
    @(posedge clk); #1;
    set_req(0, 32'd6, 32'd7, ALU_ADD);
    set_req(1, 32'd1, 32'd1, ALU_ADD);
    transact(0, 32'd13, 1'b0, 1'b0, 0, '0);

`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    check("stats_clear0", grant_cnt, '0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req_valid = '0;
      set_req((i < 3) ? 0 : 1, 32'd1, 32'd2, ALU_ADD);
      transact((i < 3) ? 0 : 1, 32'd3, 1'b0, 1'b0, 0, '0);
    end
    @(negedge clk);
    check("stats_count", grant_cnt, {16'd2, 16'd3});
    // Clear in the same cycle as a grant: clear wins.
    set_req(1, 32'd1, 32'd2, ALU_ADD);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("stats_clr_prio", grant_cnt, '0);
    @(posedge clk); #1;
    rsp_ready = oh(1);
    @(posedge clk); #1;
    rsp_ready = '0;
    exp_ptr = 0;
`endif

    // Randomised traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      vec = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        logic [DW-1:0] ra, rb;
        ra = $urandom();
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
        req_a[i*DW +: DW]    = ra;
        req_b[i*DW +: DW]    = rb;
        req_op[i*OPW +: OPW] = OPW'($urandom_range(0, 7));
      end
      win = -1;
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (vec[(exp_ptr + k) % NREQ]) win = (exp_ptr + k) % NREQ;
      end
      er = alu_fn(req_a[win*DW +: DW], req_b[win*DW +: DW], req_op[win*OPW +: OPW]);
      hold = $urandom_range(0, 2);
      req_valid = vec;
      transact(win, er, (er == '0), er[DW-1], hold, vec & ~oh(win));
      req_valid = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
